// File: rtl/credit_bcd_formatter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | credit_bcd_formatter: binary credit -> four display digit codes          |
// | (double-dabble). Revision: 1.0                                           |
// +--------------------------------------------------------------------------+
module credit_bcd_formatter #(
  parameter int         BIN_W      = 14,
  parameter int         MAX_VAL    = 9999,
  parameter logic [3:0] BLANK_CODE = 4'hA,
  parameter logic [3:0] OVF_CODE   = 4'hF,
  parameter bit         LZB        = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dig4,
  output logic             ovf
);

  localparam int                 c_SR_W     = 16 + BIN_W;
  localparam int                 c_CNT_W    = $clog2(BIN_W + 1);
  localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(BIN_W - 1);
  localparam logic [31:0]        c_MAX      = 32'(MAX_VAL);
  localparam logic [3:0]         c_RST_LEAD = LZB ? BLANK_CODE : 4'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FMT   = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_SR_W-1:0]   r_sr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_ovf_pend;

  logic [15:0]         w_bcd_adj;
  logic [c_SR_W-1:0]   w_sr_next;
  logic [31:0]         w_value_ext;
  logic                w_over;
  logic [3:0]          w_n3, w_n2, w_n1, w_n0;
  logic                w_z1, w_z2, w_z3;
  logic [3:0]          w_f1, w_f2, w_f3, w_f4;

  // Add-3 correction of every BCD nibble, all from the current register value
  for (genvar i = 0; i < 4; i++) begin : g_nib
    logic [3:0] w_nib;
    assign w_nib = r_sr[BIN_W + 4*i +: 4];
    assign w_bcd_adj[4*i +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
  end

  assign w_sr_next   = {w_bcd_adj[14:0], r_sr[BIN_W-1:0], 1'b0};
  assign w_value_ext = 32'(value);
  assign w_over      = (w_value_ext > c_MAX);

  assign w_n3 = r_sr[c_SR_W-1  -: 4];
  assign w_n2 = r_sr[c_SR_W-5  -: 4];
  assign w_n1 = r_sr[c_SR_W-9  -: 4];
  assign w_n0 = r_sr[c_SR_W-13 -: 4];

  // Leading-zero chain: a position blanks only if everything left of it is zero too
  assign w_z1 = (w_n3 == 4'd0);
  assign w_z2 = w_z1 && (w_n2 == 4'd0);
  assign w_z3 = w_z2 && (w_n1 == 4'd0);

  always_comb begin
    w_f1 = w_n3;
    w_f2 = w_n2;
    w_f3 = w_n1;
    w_f4 = w_n0;
    if (r_ovf_pend) begin
      w_f1 = OVF_CODE;
      w_f2 = OVF_CODE;
      w_f3 = OVF_CODE;
      w_f4 = OVF_CODE;
    end else if (LZB) begin
      if (w_z1) w_f1 = BLANK_CODE;
      if (w_z2) w_f2 = BLANK_CODE;
      if (w_z3) w_f3 = BLANK_CODE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      dig1       <= c_RST_LEAD;
      dig2       <= c_RST_LEAD;
      dig3       <= c_RST_LEAD;
      dig4       <= 4'h0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr       <= {16'h0000, value};
            r_cnt      <= '0;
            r_ovf_pend <= w_over;
            busy       <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) r_state <= S_FMT;
        end
        S_FMT: begin
          dig1    <= w_f1;
          dig2    <= w_f2;
          dig3    <= w_f3;
          dig4    <= w_f4;
          ovf     <= r_ovf_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_credit_bcd_formatter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_credit_bcd_formatter: scoreboard bench, LZB=1 and LZB=0 instances.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_credit_bcd_formatter;

  localparam int BIN_W = 14;

  logic clk = 1'b0;
  logic clr, start;
  logic [BIN_W-1:0] value;

  logic busy1, done1, ovf1;
  logic [3:0] a1, a2, a3, a4;
  logic busy0, done0, ovf0;
  logic [3:0] b1, b2, b3, b4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  credit_bcd_formatter #(.BIN_W(BIN_W), .LZB(1'b1)) dut_lzb (
    .clk(clk), .clr(clr), .start(start), .value(value),
    .busy(busy1), .done(done1),
    .dig1(a1), .dig2(a2), .dig3(a3), .dig4(a4), .ovf(ovf1)
  );

  credit_bcd_formatter #(.BIN_W(BIN_W), .LZB(1'b0)) dut_nolzb (
    .clk(clk), .clr(clr), .start(start), .value(value),
    .busy(busy0), .done(done0),
    .dig1(b1), .dig2(b2), .dig3(b3), .dig4(b4), .ovf(ovf0)
  );

  typedef struct packed {
    logic [15:0] lz;
    logic [15:0] nz;
    logic        ovf;
  } exp_t;

  localparam exp_t c_RESET = '{lz: 16'hAAA0, nz: 16'h0000, ovf: 1'b0};

  // Reference: decimal digits by plain arithmetic, blanking by magnitude
  function automatic exp_t ref_fmt(int v);
    exp_t e;
    int d0, d1, d2, d3;
    if (v > 9999) begin
      e.lz = 16'hFFFF; e.nz = 16'hFFFF; e.ovf = 1'b1;
    end else begin
      d0 = v / 1000; d1 = (v / 100) % 10; d2 = (v / 10) % 10; d3 = v % 10;
      e.nz  = {4'(d0), 4'(d1), 4'(d2), 4'(d3)};
      e.lz  = {(v < 1000) ? 4'hA : 4'(d0), (v < 100) ? 4'hA : 4'(d1),
               (v < 10) ? 4'hA : 4'(d2), 4'(d3)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of acceptance and completion timing
  exp_t q[$];
  exp_t m_disp = c_RESET;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_cnt  = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      q.delete();
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_disp = c_RESET;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == BIN_W + 1) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        q.push_back(ref_fmt(int'(value)));
        m_busy = 1'b1; m_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT announces new digits
  always @(posedge clk) begin
    exp_t e;
    #1;
    check("busy_lzb", 32'(busy1), 32'(m_busy));
    check("busy_nolzb", 32'(busy0), 32'(m_busy));
    check("done_lzb", 32'(done1), 32'(m_done));
    check("done_nolzb", 32'(done0), 32'(m_done));
    if (done1) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got done=1 expected no pending conversion at %0t", $time);
      end else begin
        e = q.pop_front();
        m_disp = e;
      end
    end
    check("digits_lzb", 32'({a1, a2, a3, a4}), 32'(m_disp.lz));
    check("digits_nolzb", 32'({b1, b2, b3, b4}), 32'(m_disp.nz));
    check("ovf_lzb", 32'(ovf1), 32'(m_disp.ovf));
    check("ovf_nolzb", 32'(ovf0), 32'(m_disp.ovf));
  end

  task automatic conv(int v, int gap);
    @(negedge clk);
    start = 1'b1;
    value = 14'(v);
    @(negedge clk);
    start = 1'b0;
    value = 14'($urandom);
    repeat (BIN_W + 1 + gap) @(negedge clk);
  endtask

  initial begin
    int dirs[8] = '{1234, 7, 40, 1005, 0, 9999, 10000, 16383};
    int n;
    clr = 1'b1; start = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    foreach (dirs[i]) conv(dirs[i], 1);

    // Second start while busy is ignored; held start re-accepts after return to idle
    @(negedge clk);
    start = 1'b1; value = 14'd1234;
    @(negedge clk);
    repeat (4) @(negedge clk);
    value = 14'd5678;
    repeat (40) begin
      @(negedge clk);
      value = 14'($urandom_range(0, 16383));
    end
    start = 1'b0;
    repeat (BIN_W + 3) @(negedge clk);

    // Asynchronous clear mid-conversion
    @(negedge clk);
    start = 1'b1; value = 14'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_busy", 32'(busy1), 32'd0);
    check("clr_done", 32'(done1), 32'd0);
    check("clr_digits_lzb", 32'({a1, a2, a3, a4}), 32'h0000AAA0);
    check("clr_digits_nolzb", 32'({b1, b2, b3, b4}), 32'h00000000);
    @(negedge clk);
    clr = 1'b0;
    repeat (BIN_W + 3) @(negedge clk);
    conv(4321, 1);

    // Randomized traffic: mixed ranges, gaps and back-to-back holds
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: n = $urandom_range(0, 99);
        1: n = $urandom_range(0, 9999);
        2: n = $urandom_range(9990, 10010);
        default: n = $urandom_range(0, 16383);
      endcase
      conv(n, $urandom_range(0, 3));
    end

    begin
      int budget = 100;
      while ((q.size() != 0 || m_busy) && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        tests++; fails++;
        $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
